// File: rtl/rf_dump_pkg.sv
// Shared definitions for the register-file debug dump sequencer.
// Geometry of the SISC register file and the sequencer state encoding.
package rf_dump_pkg;

   localparam int RF_AW = 4;
   localparam int RF_DW = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      CAPT  = 3'd2,
      SEND  = 3'd3,
      FIN   = 3'd4
   } state_t;

endpackage

// File: rtl/rf_dump.sv
// Walks a register-file address range through the clocked A port and streams each word out.
// First word valid 2 cycles after ISSUE entry, 3 cycles/word; SEND holds the word until dout_ready.
module rf_dump
   import rf_dump_pkg::*;
(
   input  logic             clk,
   input  logic             rst_f,
   input  logic             dump_req,
   input  logic             halted,
   input  logic [RF_AW-1:0] first_reg,
   input  logic [RF_AW-1:0] last_reg,
   output logic [RF_AW-1:0] rf_rd_addr,
   input  logic [RF_DW-1:0] rf_rd_data,
   output logic             dbg_active,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic [RF_DW-1:0] dout_data,
   output logic [RF_AW-1:0] dout_addr,
   output logic             dout_last,
   output logic             done,
   output logic             aborted
);

   state_t           state, state_nx;
   logic [RF_AW-1:0] cur, cur_nx;
   logic [RF_AW-1:0] end_reg, end_nx;
   logic [RF_AW-1:0] rd_addr_nx, dout_addr_nx;
   logic [RF_DW-1:0] dout_data_nx;
   logic             dout_valid_nx, dout_last_nx, done_nx, aborted_nx;
   logic             abort, xfer, at_end;

   // Losing halted mid-dump cancels everything, even a same-cycle transfer.
   assign abort      = ((state == ISSUE) || (state == CAPT) || (state == SEND)) && !halted;
   assign xfer       = dout_valid && dout_ready;
   assign at_end     = (cur == end_reg);
   assign dbg_active = (state != IDLE);

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state      <= IDLE;
         cur        <= '0;
         end_reg    <= '0;
         rf_rd_addr <= '0;
         dout_valid <= 1'b0;
         dout_data  <= '0;
         dout_addr  <= '0;
         dout_last  <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
      end else begin
         state      <= state_nx;
         cur        <= cur_nx;
         end_reg    <= end_nx;
         rf_rd_addr <= rd_addr_nx;
         dout_valid <= dout_valid_nx;
         dout_data  <= dout_data_nx;
         dout_addr  <= dout_addr_nx;
         dout_last  <= dout_last_nx;
         done       <= done_nx;
         aborted    <= aborted_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (dump_req && halted) state_nx = ISSUE;
         ISSUE:   state_nx = CAPT;
         CAPT:    state_nx = SEND;
         SEND:    if (xfer) state_nx = at_end ? FIN : ISSUE;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (abort) state_nx = IDLE;
   end

   always_comb begin
      cur_nx        = cur;
      end_nx        = end_reg;
      rd_addr_nx    = rf_rd_addr;
      dout_valid_nx = dout_valid;
      dout_data_nx  = dout_data;
      dout_addr_nx  = dout_addr;
      dout_last_nx  = dout_last;
      done_nx       = (state_nx == FIN);
      aborted_nx    = abort;
      case (state)
         IDLE: begin
            if (dump_req && halted) begin
               cur_nx     = first_reg;
               end_nx     = last_reg;
               rd_addr_nx = first_reg;
            end
         end
         CAPT: begin
            dout_valid_nx = 1'b1;
            dout_data_nx  = rf_rd_data;
            dout_addr_nx  = cur;
            dout_last_nx  = at_end;
         end
         SEND: begin
            if (xfer) begin
               dout_valid_nx = 1'b0;
               if (!at_end) begin
                  cur_nx     = cur + 4'd1;
                  rd_addr_nx = cur + 4'd1;
               end
            end
         end
         default: ;
      endcase
      if (abort) dout_valid_nx = 1'b0;
   end

endmodule

// File: tb/tb_rf_dump.sv
// Self-checking bench for rf_dump: clocked register-file model plus range/word reference model.
module tb_rf_dump;

   logic        clk = 1'b0;
   logic        rst_f = 1'b1;
   logic        dump_req = 1'b0;
   logic        halted = 1'b0;
   logic [3:0]  first_reg = 4'd0;
   logic [3:0]  last_reg = 4'd0;
   logic [3:0]  rf_rd_addr;
   logic [31:0] rf_rd_data;
   logic        dbg_active;
   logic        dout_valid;
   logic        dout_ready = 1'b1;
   logic [31:0] dout_data;
   logic [3:0]  dout_addr;
   logic        dout_last;
   logic        done;
   logic        aborted;

   int vectors = 0;
   int miscompares = 0;

   rf_dump dut (
      .clk(clk), .rst_f(rst_f), .dump_req(dump_req), .halted(halted),
      .first_reg(first_reg), .last_reg(last_reg), .rf_rd_addr(rf_rd_addr),
      .rf_rd_data(rf_rd_data), .dbg_active(dbg_active), .dout_valid(dout_valid),
      .dout_ready(dout_ready), .dout_data(dout_data), .dout_addr(dout_addr),
      .dout_last(dout_last), .done(done), .aborted(aborted)
   );

   always #5 clk = ~clk;

   // Register file with a clocked A read port; R0 is hardwired to zero.
   logic [31:0] regs [16];
   logic [3:0]  rd_a;
   assign rd_a = dbg_active ? rf_rd_addr : 4'd0;
   always @(posedge clk) rf_rd_data <= (rd_a == 4'd0) ? 32'd0 : regs[rd_a];

   // Results collected by run_dump.
   logic [3:0]  q_addr[$];
   logic [31:0] q_data[$];
   logic        q_last[$];
   int n_done, n_abort, done_cyc, last_xfer_cyc, first_valid_cyc, active_cyc, hold_err;
   bit timed_out;

   function automatic logic [31:0] exp_data(input logic [3:0] a);
      return (a == 4'd0) ? 32'd0 : regs[a];
   endfunction

   function automatic int exp_count(input logic [3:0] f, input logic [3:0] l);
      logic [3:0] d;
      d = l - f;
      return int'(d) + 1;
   endfunction

   // Starts a dump and records every accepted word; stall_idx/stall_len hold ready low on one word.
   task automatic run_dump(input logic [3:0] f, input logic [3:0] l, input int stall_idx,
                           input int stall_len, input int rand_pct, input bit spurious);
      int cyc, stall_cnt;
      bit prev_hold;
      logic [31:0] h_data;
      logic [3:0]  h_addr;
      logic        h_last;
      q_addr.delete(); q_data.delete(); q_last.delete();
      n_done = 0; n_abort = 0; done_cyc = -1; last_xfer_cyc = -1; first_valid_cyc = -1;
      active_cyc = 0; hold_err = 0; timed_out = 0;
      cyc = 0; stall_cnt = 0; prev_hold = 0; h_data = '0; h_addr = '0; h_last = 1'b0;
      @(negedge clk);
      first_reg = f; last_reg = l; halted = 1'b1; dump_req = 1'b1; dout_ready = 1'b1;
      while (1) begin
         @(negedge clk);
         cyc++;
         dump_req = 1'b0;
         if (cyc == 1) begin
            first_reg = 4'($urandom_range(15));
            last_reg  = 4'($urandom_range(15));
         end
         if (spurious && cyc == 2) dump_req = 1'b1;
         if (dbg_active) active_cyc++;
         if (done) begin n_done++; done_cyc = cyc; end
         if (aborted) n_abort++;
         if (prev_hold && (dout_valid !== 1'b1 || dout_data !== h_data ||
                           dout_addr !== h_addr || dout_last !== h_last)) hold_err++;
         if (dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (dout_valid && q_addr.size() == stall_idx && stall_cnt < stall_len) begin
            dout_ready = 1'b0;
            stall_cnt++;
         end else if (rand_pct > 0) begin
            dout_ready = ($urandom_range(99) >= rand_pct);
         end else begin
            dout_ready = 1'b1;
         end
         if (dout_valid && dout_ready) begin
            q_addr.push_back(dout_addr); q_data.push_back(dout_data); q_last.push_back(dout_last);
            last_xfer_cyc = cyc;
            prev_hold = 1'b0;
         end else begin
            prev_hold = dout_valid;
            h_data = dout_data; h_addr = dout_addr; h_last = dout_last;
         end
         if (cyc > 1 && !dbg_active) break;
         if (cyc >= 600) begin timed_out = 1; break; end
      end
      dout_ready = 1'b1;
   endtask

   task automatic test_reset();
      #2 rst_f = 1'b0;
      #1;
      vectors++;
      if ({dbg_active, dout_valid, dout_last, done, aborted} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b, want 00000", {dbg_active, dout_valid, dout_last, done, aborted});
      end
      vectors++;
      if ({rf_rd_addr, dout_addr, dout_data} !== 40'd0) begin
         miscompares++;
         $display("FAIL reset_regs: rd_addr=%0h addr=%0h data=%0h, want 0", rf_rd_addr, dout_addr, dout_data);
      end
      repeat (2) @(negedge clk);
      rst_f = 1'b1;
      @(negedge clk);
      vectors++;
      if (dbg_active !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: dbg_active=%b, want 0", dbg_active);
      end
   endtask

   task automatic test_full_dump();
      for (int i = 0; i < 16; i++) regs[i] = 32'hA500_0000 + 32'(i);
      run_dump(4'd0, 4'd15, -1, 0, 0, 1'b0);
      vectors++;
      if (timed_out || q_addr.size() !== 16) begin
         miscompares++;
         $display("FAIL full_count: got %0d words (timeout=%0d), want 16", q_addr.size(), timed_out);
      end
      for (int k = 0; k < q_addr.size(); k++) begin
         vectors++;
         if ({q_addr[k], q_data[k], q_last[k]} !== {4'(k), exp_data(4'(k)), k == 15}) begin
            miscompares++;
            $display("FAIL full_word%0d: got a=%0h d=%0h l=%b, want a=%0h d=%0h l=%b", k,
                     q_addr[k], q_data[k], q_last[k], 4'(k), exp_data(4'(k)), k == 15);
         end
      end
      vectors++;
      if (first_valid_cyc !== 3) begin
         miscompares++;
         $display("FAIL full_latency: first valid at cycle %0d, want 3", first_valid_cyc);
      end
      vectors++;
      if (n_done !== 1 || done_cyc !== last_xfer_cyc + 1 || last_xfer_cyc !== 48) begin
         miscompares++;
         $display("FAIL full_done: n=%0d done@%0d last@%0d, want 1 done@49 last@48", n_done, done_cyc, last_xfer_cyc);
      end
      vectors++;
      if (active_cyc !== 49 || n_abort !== 0) begin
         miscompares++;
         $display("FAIL full_active: active=%0d aborts=%0d, want 49 and 0", active_cyc, n_abort);
      end
   endtask

   task automatic test_wrap();
      logic [3:0] want [4];
      want[0] = 4'd14; want[1] = 4'd15; want[2] = 4'd0; want[3] = 4'd1;
      run_dump(4'd14, 4'd1, -1, 0, 0, 1'b0);
      vectors++;
      if (timed_out || q_addr.size() !== 4) begin
         miscompares++;
         $display("FAIL wrap_count: got %0d words, want 4", q_addr.size());
      end
      for (int k = 0; k < q_addr.size() && k < 4; k++) begin
         vectors++;
         if ({q_addr[k], q_data[k], q_last[k]} !== {want[k], exp_data(want[k]), k == 3}) begin
            miscompares++;
            $display("FAIL wrap_word%0d: got a=%0h d=%0h l=%b, want a=%0h d=%0h l=%b", k,
                     q_addr[k], q_data[k], q_last[k], want[k], exp_data(want[k]), k == 3);
         end
      end
      vectors++;
      if (n_done !== 1) begin
         miscompares++;
         $display("FAIL wrap_done: got %0d pulses, want 1", n_done);
      end
   endtask

   task automatic test_single();
      run_dump(4'd5, 4'd5, -1, 0, 0, 1'b0);
      vectors++;
      if (q_addr.size() !== 1) begin
         miscompares++;
         $display("FAIL single_count: got %0d words, want 1", q_addr.size());
      end else begin
         vectors++;
         if ({q_addr[0], q_data[0], q_last[0]} !== {4'd5, exp_data(4'd5), 1'b1}) begin
            miscompares++;
            $display("FAIL single_word: got a=%0h d=%0h l=%b, want a=5 d=%0h l=1",
                     q_addr[0], q_data[0], q_last[0], exp_data(4'd5));
         end
      end
      vectors++;
      if (active_cyc !== 4 || n_done !== 1) begin
         miscompares++;
         $display("FAIL single_active: active=%0d done=%0d, want 4 and 1", active_cyc, n_done);
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] f, a;
      f = 4'($urandom_range(15));
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      run_dump(f, f + 4'd6, 3, 5, 0, 1'b0);
      vectors++;
      if (timed_out || q_addr.size() !== 7) begin
         miscompares++;
         $display("FAIL bp_count: got %0d words, want 7", q_addr.size());
      end
      for (int k = 0; k < q_addr.size(); k++) begin
         a = f + 4'(k);
         vectors++;
         if ({q_addr[k], q_data[k], q_last[k]} !== {a, exp_data(a), k == 6}) begin
            miscompares++;
            $display("FAIL bp_word%0d: got a=%0h d=%0h l=%b, want a=%0h d=%0h l=%b", k,
                     q_addr[k], q_data[k], q_last[k], a, exp_data(a), k == 6);
         end
      end
      vectors++;
      if (hold_err !== 0 || active_cyc !== 27 || n_done !== 1) begin
         miscompares++;
         $display("FAIL bp_hold: hold_err=%0d active=%0d done=%0d, want 0 27 1", hold_err, active_cyc, n_done);
      end
   endtask

   task automatic test_abort();
      logic [3:0] f;
      int dlv;
      bit found;
      f = 4'($urandom_range(15));
      found = 0; dlv = 0;
      @(negedge clk);
      first_reg = f; last_reg = f + 4'd5; halted = 1'b1; dump_req = 1'b1; dout_ready = 1'b1;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         dump_req = 1'b0;
         if (dout_valid && dout_addr == f + 4'd2) begin
            dout_ready = 1'b0;
            found = 1;
         end else if (dout_valid) begin
            dlv++;
         end
      end
      vectors++;
      if (!found || dlv !== 2) begin
         miscompares++;
         $display("FAIL abort_reach: found=%0d delivered=%0d, want 1 and 2", found, dlv);
      end
      @(negedge clk);
      halted = 1'b0;
      @(negedge clk);
      vectors++;
      if ({aborted, dout_valid, dbg_active, done} !== 4'b1000) begin
         miscompares++;
         $display("FAIL abort_pulse: aborted,valid,active,done=%b, want 1000", {aborted, dout_valid, dbg_active, done});
      end
      @(negedge clk);
      vectors++;
      if ({aborted, done, dbg_active} !== 3'b000) begin
         miscompares++;
         $display("FAIL abort_after: aborted,done,active=%b, want 000", {aborted, done, dbg_active});
      end
      run_dump(f, f + 4'd1, -1, 0, 0, 1'b0);
      vectors++;
      if (q_addr.size() !== 2 || n_done !== 1 || n_abort !== 0) begin
         miscompares++;
         $display("FAIL abort_restart: words=%0d done=%0d aborts=%0d, want 2 1 0", q_addr.size(), n_done, n_abort);
      end else begin
         vectors++;
         if ({q_addr[0], q_data[0], q_addr[1], q_last[1]} !== {f, exp_data(f), f + 4'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL abort_restart_words: got a0=%0h d0=%0h a1=%0h, want a0=%0h d0=%0h a1=%0h",
                     q_addr[0], q_data[0], q_addr[1], f, exp_data(f), f + 4'd1);
         end
      end
   endtask

   task automatic test_ignored();
      int seen;
      seen = 0;
      @(negedge clk);
      halted = 1'b0; dump_req = 1'b1;
      @(negedge clk);
      dump_req = 1'b0;
      if (dbg_active || dout_valid) seen++;
      halted = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (dbg_active || dout_valid) seen++;
      end
      vectors++;
      if (seen !== 0) begin
         miscompares++;
         $display("FAIL ignored_req: active for %0d cycles, want 0", seen);
      end
   endtask

   task automatic test_random();
      logic [3:0] f, l, a;
      int n;
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < 16; i++) regs[i] = $urandom;
         f = 4'($urandom_range(15));
         l = 4'($urandom_range(15));
         n = exp_count(f, l);
         run_dump(f, l, -1, 0, 40, 1'b1);
         vectors++;
         if (timed_out || q_addr.size() !== n) begin
            miscompares++;
            $display("FAIL rand%0d_count: got %0d words, want %0d", it, q_addr.size(), n);
         end
         for (int k = 0; k < q_addr.size(); k++) begin
            a = f + 4'(k);
            vectors++;
            if ({q_addr[k], q_data[k], q_last[k]} !== {a, exp_data(a), k == n - 1}) begin
               miscompares++;
               $display("FAIL rand%0d_word%0d: got a=%0h d=%0h l=%b, want a=%0h d=%0h l=%b", it, k,
                        q_addr[k], q_data[k], q_last[k], a, exp_data(a), k == n - 1);
            end
         end
         vectors++;
         if (hold_err !== 0 || n_done !== 1 || n_abort !== 0) begin
            miscompares++;
            $display("FAIL rand%0d_ctrl: hold_err=%0d done=%0d aborts=%0d, want 0 1 0", it, hold_err, n_done, n_abort);
         end
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      bit found;
      seen = 0; found = 0;
      @(negedge clk);
      first_reg = 4'd0; last_reg = 4'd15; halted = 1'b1; dump_req = 1'b1; dout_ready = 1'b1;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         dump_req = 1'b0;
         if (dout_valid && dout_addr == 4'd1) found = 1;
      end
      rst_f = 1'b0;
      #1;
      vectors++;
      if (!found || {dbg_active, dout_valid, dout_last, done, aborted} !== 5'b0) begin
         miscompares++;
         $display("FAIL rstmid_flags: found=%0d flags=%b, want 1 and 00000", found,
                  {dbg_active, dout_valid, dout_last, done, aborted});
      end
      vectors++;
      if ({rf_rd_addr, dout_addr, dout_data} !== 40'd0) begin
         miscompares++;
         $display("FAIL rstmid_regs: rd_addr=%0h addr=%0h data=%0h, want 0", rf_rd_addr, dout_addr, dout_data);
      end
      @(negedge clk);
      rst_f = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (dbg_active || dout_valid || done || aborted) seen++;
      end
      vectors++;
      if (seen !== 0) begin
         miscompares++;
         $display("FAIL rstmid_quiet: activity in %0d cycles after reset, want 0", seen);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 32'd0;
      test_reset();
      test_full_dump();
      test_wrap();
      test_single();
      test_backpressure();
      test_abort();
      test_ignored();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
